// File: rtl/ws2812_frame_tx.sv
// WS2812-class LED chain transmitter: streams pixel words MSB-first as timed pulses, then a latch low period.
// Define WS2812_OUTPUT_INVERT_EN to invert DO at the output flop, for inverting level shifters.
module ws2812_frame_tx #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int T0H_CYCLES     = 8,
  parameter int T0L_CYCLES     = 17,
  parameter int T1H_CYCLES     = 16,
  parameter int T1L_CYCLES     = 9,
  parameter int RESET_CYCLES   = 6000,
  parameter int MAX_GAP_CYCLES = 4,
  parameter int LED_CNT_W      = 10
) (
  input  logic                      Clock,
  input  logic                      cRst_n,
  input  logic                      Start,
  input  logic [LED_CNT_W-1:0]      Led_Count,
  input  logic [BITS_PER_PIXEL-1:0] Pixel_Data,
  input  logic                      Pixel_Valid,
  output logic                      Pixel_Ready,
  output logic                      Busy,
  output logic                      Frame_Done,
  output logic                      Underrun,
  output logic                      DO
);
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = maxOf(maxOf(maxOf(T0H_CYCLES, T0L_CYCLES), maxOf(T1H_CYCLES, T1L_CYCLES)),
                               maxOf(RESET_CYCLES, MAX_GAP_CYCLES));
  localparam int CNT_W = $clog2(MAX_T) + 1;
  localparam int BI_W  = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

  // Counters run down to zero, so each phase loads its length minus one.
  localparam logic [CNT_W-1:0] T0H_LD = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0L_LD = CNT_W'(T0L_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_LD = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1L_LD = CNT_W'(T1L_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(MAX_GAP_CYCLES - 1);
  localparam logic [BI_W-1:0]  MSB_IDX = BI_W'(BITS_PER_PIXEL - 1);

`ifdef WS2812_OUTPUT_INVERT_EN
  localparam logic DO_IDLE = 1'b1;
`else
  localparam logic DO_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {sIdle, sLoad, sHigh, sLow, sReset} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [BI_W-1:0]           bitIdx;
  logic [BITS_PER_PIXEL-1:0] shReg;
  logic [BITS_PER_PIXEL-1:0] shNext;
  logic [LED_CNT_W-1:0]      remaining;
  logic                      firstPix;

  assign Pixel_Ready = (state == sLoad);
  assign shNext      = shReg << 1;

  always_ff @(posedge Clock or negedge cRst_n) begin
    if (!cRst_n) begin
      state      <= sIdle;
      cnt        <= '0;
      bitIdx     <= '0;
      shReg      <= '0;
      remaining  <= '0;
      firstPix   <= 1'b0;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      Underrun   <= 1'b0;
      DO         <= DO_IDLE;
    end else begin
      Frame_Done <= 1'b0;
      Underrun   <= 1'b0;
      // DO mirrors the state one clock late, so every pulse width equals its state dwell.
      DO         <= (state == sHigh) ? ~DO_IDLE : DO_IDLE;
      case (state)
        sIdle: begin
          if (Start) begin
            Busy <= 1'b1;
            if (Led_Count != '0) begin
              remaining <= Led_Count;
              firstPix  <= 1'b1;
              state     <= sLoad;
            end else begin
              cnt   <= RST_LD;
              state <= sReset;
            end
          end
        end
        sLoad: begin
          if (Pixel_Valid) begin
            shReg     <= Pixel_Data;
            bitIdx    <= MSB_IDX;
            remaining <= remaining - 1'b1;
            firstPix  <= 1'b0;
            cnt       <= Pixel_Data[BITS_PER_PIXEL-1] ? T1H_LD : T0H_LD;
            state     <= sHigh;
          end else if (!firstPix) begin
            // Only later pixels are time-limited; a late one aborts the frame.
            if (cnt == '0) begin
              Underrun <= 1'b1;
              cnt      <= RST_LD;
              state    <= sReset;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        sHigh: begin
          if (cnt == '0) begin
            cnt   <= shReg[BITS_PER_PIXEL-1] ? T1L_LD : T0L_LD;
            state <= sLow;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        sLow: begin
          if (cnt == '0) begin
            if (bitIdx != '0) begin
              shReg  <= shNext;
              bitIdx <= bitIdx - 1'b1;
              cnt    <= shNext[BITS_PER_PIXEL-1] ? T1H_LD : T0H_LD;
              state  <= sHigh;
            end else if (remaining != '0) begin
              cnt   <= GAP_LD;
              state <= sLoad;
            end else begin
              cnt   <= RST_LD;
              state <= sReset;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        sReset: begin
          if (cnt == '0) begin
            Frame_Done <= 1'b1;
            Busy       <= 1'b0;
            state      <= sIdle;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= sIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: directed and random frames against a run-length waveform model.
module tb_ws2812_frame_tx;
  localparam int BPP = 24;
  localparam int T0H = 8;
  localparam int T0L = 17;
  localparam int T1H = 16;
  localparam int T1L = 9;
  localparam int RST = 6000;
  localparam int GAP = 4;
  localparam int LW  = 10;
`ifdef WS2812_OUTPUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic           Clock = 1'b0;
  logic           cRst_n = 1'b0;
  logic           Start = 1'b0;
  logic [LW-1:0]  Led_Count = '0;
  logic [BPP-1:0] Pixel_Data = '0;
  logic           Pixel_Valid = 1'b0;
  logic           Pixel_Ready, Busy, Frame_Done, Underrun, DO;

  ws2812_frame_tx #(
    .BITS_PER_PIXEL(BPP), .T0H_CYCLES(T0H), .T0L_CYCLES(T0L), .T1H_CYCLES(T1H),
    .T1L_CYCLES(T1L), .RESET_CYCLES(RST), .MAX_GAP_CYCLES(GAP), .LED_CNT_W(LW)
  ) dut (
    .Clock(Clock), .cRst_n(cRst_n), .Start(Start), .Led_Count(Led_Count),
    .Pixel_Data(Pixel_Data), .Pixel_Valid(Pixel_Valid), .Pixel_Ready(Pixel_Ready),
    .Busy(Busy), .Frame_Done(Frame_Done), .Underrun(Underrun), .DO(DO)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Monitor: one sample per cycle, taken on the falling edge.
  logic doQ[$];
  int hsCnt = 0, fdCnt = 0, urCnt = 0, rdyCnt = 0;
  always @(negedge Clock) begin
    doQ.push_back(DO ^ INV);
    if (Pixel_Ready) rdyCnt++;
    if (Pixel_Valid && Pixel_Ready) hsCnt++;
    if (Frame_Done) fdCnt++;
    if (Underrun) urCnt++;
  end

  logic [BPP-1:0] framePix[$];
  int frameHold[$];
  int expRuns[$];
  int gotRuns[$];
  int expHs, expUr, expRdy, lastLen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs are signed lengths: positive = logical high, negative = logical low.
  function automatic void addSeg(input bit lvl, input int len);
    int v = lvl ? len : -len;
    if (expRuns.size() > 0 && ((expRuns[$] > 0) == lvl)) expRuns[expRuns.size()-1] += v;
    else expRuns.push_back(v);
  endfunction

  // Reference: the waveform seen from the cycle after Start up to the Frame_Done cycle.
  function automatic void buildExp(input int n);
    expRuns.delete();
    expHs = 0; expUr = 0; expRdy = 0;
    if (n == 0) begin
      addSeg(0, RST + 1);
      return;
    end
    addSeg(0, frameHold[0] + 2);
    expRdy = frameHold[0] + 1;
    expHs = 1;
    for (int p = 0; p < n; p++) begin
      for (int b = BPP - 1; b >= 0; b--) begin
        bit one = framePix[p][b];
        addSeg(1, one ? T1H : T0H);
        addSeg(0, one ? T1L : T0L);
      end
      if (p == n - 1) begin
        addSeg(0, RST);
        break;
      end
      if (frameHold[p+1] >= GAP) begin
        addSeg(0, GAP + RST);
        expUr = 1;
        expRdy += GAP;
        break;
      end
      addSeg(0, frameHold[p+1] + 1);
      expRdy += frameHold[p+1] + 1;
      expHs++;
    end
  endfunction

  task automatic runFrame(input string name, input int n, input int startAt);
    int base, hs0, fd0, ur0, rdy0, idx, cyc, endIdx, mm;
    logic done, busyAtDone;
    int holdRem[$];
    holdRem = frameHold;
    buildExp(n);
    Led_Count = LW'(n);
    Start = 1'b1;
    Pixel_Valid = (framePix.size() > 0) && (holdRem[0] == 0);
    if (framePix.size() > 0) Pixel_Data = framePix[0];
    tick();
    Start = 1'b0;
    base = doQ.size(); hs0 = hsCnt; fd0 = fdCnt; ur0 = urCnt; rdy0 = rdyCnt;
    chk({name, "_busy_rise"}, Busy, 1);
    done = 1'b0; busyAtDone = 1'b1; cyc = 0;
    while (!done && cyc < 20000) begin
      idx = hsCnt - hs0;
      if (idx < framePix.size()) begin
        Pixel_Data = framePix[idx];
        if (holdRem[idx] > 0) begin
          Pixel_Valid = 1'b0;
          if (Pixel_Ready) holdRem[idx]--;
        end else begin
          Pixel_Valid = 1'b1;
        end
      end else begin
        Pixel_Valid = 1'b0;
      end
      Start = (cyc == startAt);
      if (cyc == startAt) Led_Count = 7;
      tick();
      cyc++;
      if (Frame_Done) begin
        done = 1'b1;
        busyAtDone = Busy;
      end
    end
    Start = 1'b0;
    Pixel_Valid = 1'b0;
    chk({name, "_frame_done_seen"}, done, 1);
    chk({name, "_busy_at_done"}, busyAtDone, 0);
    @(negedge Clock);
    #1;
    endIdx = doQ.size();
    lastLen = endIdx - base;
    gotRuns.delete();
    for (int i = base; i < endIdx; i++) begin
      bit lv = doQ[i];
      if (gotRuns.size() > 0 && ((gotRuns[$] > 0) == lv)) gotRuns[gotRuns.size()-1] += lv ? 1 : -1;
      else gotRuns.push_back(lv ? 1 : -1);
    end
    chk({name, "_run_count"}, gotRuns.size(), expRuns.size());
    mm = -1;
    for (int i = 0; i < gotRuns.size() && i < expRuns.size(); i++)
      if (mm < 0 && gotRuns[i] != expRuns[i]) mm = i;
    if (mm >= 0) $display("  %s run %0d: got %0d expected %0d (negative = low)", name, mm, gotRuns[mm], expRuns[mm]);
    chk({name, "_first_bad_run"}, mm, -1);
    chk({name, "_handshakes"}, hsCnt - hs0, expHs);
    chk({name, "_underruns"}, urCnt - ur0, expUr);
    chk({name, "_ready_cycles"}, rdyCnt - rdy0, expRdy);
    repeat (3) tick();
    chk({name, "_idle_busy"}, Busy, 0);
    chk({name, "_idle_do"}, DO, INV);
    chk({name, "_done_pulses"}, fdCnt - fd0, 1);
  endtask

  initial begin
    int n, fd0, ur0, cyc;
    #2;
    chk("rst_do", DO, INV);
    chk("rst_busy", Busy, 0);
    chk("rst_ready", Pixel_Ready, 0);
    chk("rst_done", Frame_Done, 0);
    chk("rst_underrun", Underrun, 0);
    @(negedge Clock); #1;
    cRst_n = 1'b1;
    repeat (2) tick();

    // 1: single pixel, MSB only set
    framePix = '{24'h800000}; frameHold = '{0};
    runFrame("s1", 1, -1);
    chk("s1_total_len", lastLen, 2 + 25 + 23 * 25 + RST);

    // 2: three pixels, valid held high; stray Start and Led_Count change mid-frame
    framePix = '{24'hFF0000, 24'h00FF00, 24'h0000FF}; frameHold = '{0, 0, 0};
    runFrame("s2", 3, 40);

    // 3: second pixel late by 5 LOAD cycles -> underrun
    framePix = '{BPP'($urandom), BPP'($urandom)}; frameHold = '{0, 5};
    runFrame("s3", 2, -1);

    // 3b: second pixel arrives on the last allowed LOAD cycle
    framePix = '{BPP'($urandom), BPP'($urandom)}; frameHold = '{1, GAP - 1};
    runFrame("s3b", 2, -1);

    // 4: latch-only frame
    framePix.delete(); frameHold.delete();
    runFrame("s4", 0, -1);
    chk("s4_total_len", lastLen, RST + 1);

    // 5: reset in the middle of a high pulse
    fd0 = fdCnt; ur0 = urCnt;
    Led_Count = 1; Pixel_Data = 24'h800000; Pixel_Valid = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 0;
    while ((DO ^ INV) !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("s5_reached_high", DO ^ INV, 1);
    repeat (3) tick();
    #2;
    cRst_n = 1'b0;
    #1;
    chk("s5_rst_do", DO, INV);
    chk("s5_rst_busy", Busy, 0);
    chk("s5_rst_ready", Pixel_Ready, 0);
    chk("s5_rst_done", Frame_Done, 0);
    chk("s5_rst_underrun", Underrun, 0);
    repeat (2) @(negedge Clock);
    #1;
    cRst_n = 1'b1;
    repeat (5) tick();
    chk("s5_post_busy", Busy, 0);
    chk("s5_post_ready", Pixel_Ready, 0);
    chk("s5_post_do", DO, INV);
    chk("s5_no_done_pulse", fdCnt - fd0, 0);
    chk("s5_no_underrun_pulse", urCnt - ur0, 0);
    Pixel_Valid = 1'b0;

    // Random frames after the reset
    for (int r = 0; r < 2; r++) begin
      n = int'($urandom_range(1, 3));
      framePix.delete(); frameHold.delete();
      for (int i = 0; i < n; i++) begin
        framePix.push_back(BPP'($urandom));
        frameHold.push_back(i == 0 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, GAP)));
      end
      runFrame("rnd", n, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
